wb_regfile: RTL and testbench



---
 rtl/wb_regfile_if.sv | 28 ++
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB write side, the two ID read ports,
// and the exported write-back value and commit count.
interface wb_regfile_if;
    logic        W_RegWrite;
    logic        W_MemtoReg;
    logic [31:0] W_ALUanswer;
    logic [31:0] W_Dout;
    logic [4:0]  W_WriteReg;
    logic [2:0]  W_load_option;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] W_WriteData;
    logic [31:0] WriteCount;

    modport master (
        output W_RegWrite, W_MemtoReg, W_ALUanswer, W_Dout, W_WriteReg, W_load_option,
        output RA1, RA2,
        input  RD1, RD2, W_WriteData, WriteCount
    );

    modport slave (
        input  W_RegWrite, W_MemtoReg, W_ALUanswer, W_Dout, W_WriteReg, W_load_option,
        input  RA1, RA2,
        output RD1, RD2, W_WriteData, WriteCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 architectural register file with commit counter.
// Define REGFILE_BYPASS_EN to make same-cycle reads of the written register see the new value.
module wb_regfile (
    input  logic         Clk,
    input  logic         Reset,
    wb_regfile_if.slave  wb
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] write_data;
    logic        commit;
    logic [31:0] regs [32];
    logic [31:0] write_count_reg;
    logic [31:0] write_count_next;
    logic [31:0] rd1;
    logic [31:0] rd2;

    // Sub-word lane selection from the low address bits; halfwords ignore bit 0.
    always_comb begin
        byte_sel = wb.W_Dout[7:0];
        case (wb.W_ALUanswer[1:0])
            2'd0: byte_sel = wb.W_Dout[7:0];
            2'd1: byte_sel = wb.W_Dout[15:8];
            2'd2: byte_sel = wb.W_Dout[23:16];
            2'd3: byte_sel = wb.W_Dout[31:24];
            default: byte_sel = wb.W_Dout[7:0];
        endcase
        half_sel = wb.W_ALUanswer[1] ? wb.W_Dout[31:16] : wb.W_Dout[15:0];
    end

    always_comb begin
        load_ext = wb.W_Dout;
        case (wb.W_load_option)
            3'd1:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    load_ext = {24'h0, byte_sel};
            3'd3:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_ext = {16'h0, half_sel};
            default: load_ext = wb.W_Dout;
        endcase
    end

    assign write_data      = wb.W_MemtoReg ? load_ext : wb.W_ALUanswer;
    assign wb.W_WriteData  = write_data;

    // Reset gates commit so the bypass path is also disabled during reset.
    assign commit = Reset && wb.W_RegWrite && (wb.W_WriteReg != 5'd0);

    assign regs[0] = 32'h0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] q_reg;
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    q_reg <= 32'h0;
                end else if (commit && (wb.W_WriteReg == 5'(gi))) begin
                    q_reg <= write_data;
                end
            end
            assign regs[gi] = q_reg;
        end
    endgenerate

    assign write_count_next = write_count_reg + 32'd1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            write_count_reg <= 32'h0;
        end else if (commit) begin
            write_count_reg <= write_count_next;
        end
    end

    assign wb.WriteCount = write_count_reg;

    always_comb begin
        rd1 = regs[wb.RA1];
        rd2 = regs[wb.RA2];
`ifdef REGFILE_BYPASS_EN
        if (commit && (wb.RA1 == wb.W_WriteReg)) rd1 = write_data;
        if (commit && (wb.RA2 == wb.W_WriteReg)) rd2 = write_data;
`endif
    end

    assign wb.RD1 = rd1;
    assign wb.RD2 = rd2;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based architectural model.
module tb_wb_regfile;
    logic Clk;
    logic Reset;
    wb_regfile_if bus ();

    wb_regfile dut (
        .Clk   (Clk),
        .Reset (Reset),
        .wb    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Load extension from the architectural rules, using shifts and masks.
    function automatic logic [31:0] ext_load(input logic [2:0] opt, input logic [1:0] b,
                                             input logic [31:0] dout);
        logic [31:0] v;
        case (opt)
            3'd1: begin
                v = (dout >> (8 * b)) & 32'hFF;
                if (v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            3'd2: v = (dout >> (8 * b)) & 32'hFF;
            3'd3: begin
                v = (dout >> (16 * b[1])) & 32'hFFFF;
                if (v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            3'd4: v = (dout >> (16 * b[1])) & 32'hFFFF;
            default: v = dout;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] ra, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (Reset && we && wr != 5'd0 && ra == wr) return wd;
`endif
        return model_regs[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_count = 32'h0;
    endtask

    task automatic idle_inputs();
        bus.W_RegWrite    = 1'b0;
        bus.W_MemtoReg    = 1'b0;
        bus.W_ALUanswer   = 32'h0;
        bus.W_Dout        = 32'h0;
        bus.W_WriteReg    = 5'd0;
        bus.W_load_option = 3'd0;
        bus.RA1           = 5'd0;
        bus.RA2           = 5'd0;
    endtask

    // One write-back transaction: check pre-edge outputs, commit, check post-edge state.
    task automatic drive_cycle(input logic we, input logic m2r, input logic [31:0] alu,
                               input logic [31:0] dout, input logic [4:0] wr,
                               input logic [2:0] opt, input logic [4:0] ra1,
                               input logic [4:0] ra2);
        logic [31:0] wd;
        @(negedge Clk);
        bus.W_RegWrite    = we;
        bus.W_MemtoReg    = m2r;
        bus.W_ALUanswer   = alu;
        bus.W_Dout        = dout;
        bus.W_WriteReg    = wr;
        bus.W_load_option = opt;
        bus.RA1           = ra1;
        bus.RA2           = ra2;
        #1;
        wd = m2r ? ext_load(opt, alu[1:0], dout) : alu;
        check("wdata", bus.W_WriteData, wd);
        check("rd1_pre", bus.RD1, exp_read(ra1, we, wr, wd));
        check("rd2_pre", bus.RD2, exp_read(ra2, we, wr, wd));
        @(posedge Clk);
        if (Reset && we && wr != 5'd0) begin
            model_regs[wr] = wd;
            model_count    = model_count + 32'd1;
        end
        #1;
        bus.W_RegWrite = 1'b0;
        #1;
        check("rd1_post", bus.RD1, exp_read(ra1, 1'b0, wr, wd));
        check("rd2_post", bus.RD2, exp_read(ra2, 1'b0, wr, wd));
        check("count", bus.WriteCount, model_count);
        $display("txn we=%0b m2r=%0b opt=%0d wr=%0d wd=%08h ra1=%0d ra2=%0d cnt=%0d",
                 we, m2r, opt, wr, wd, ra1, ra2, model_count);
    endtask

    task automatic check_ext(input logic [2:0] opt, input logic [1:0] b, input logic [31:0] exp);
        @(negedge Clk);
        bus.W_RegWrite    = 1'b0;
        bus.W_MemtoReg    = 1'b1;
        bus.W_Dout        = 32'h80FF_7F01;
        bus.W_ALUanswer   = {30'h0, b};
        bus.W_load_option = opt;
        #1;
        check($sformatf("ext_opt%0d_b%0d", opt, b), bus.W_WriteData, exp);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] wr;
        idle_inputs();
        model_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        for (int a = 0; a < 32; a++) begin
            bus.RA1 = 5'(a);
            bus.RA2 = 5'(31 - a);
            #1;
            check("rst_rd1", bus.RD1, 32'h0);
            check("rst_rd2", bus.RD2, 32'h0);
        end
        check("rst_count", bus.WriteCount, 32'h0);
        bus.W_ALUanswer = 32'hCAFE_F00D;
        #1;
        check("rst_wdata", bus.W_WriteData, 32'hCAFE_F00D);
        @(negedge Clk);
        Reset = 1'b1;

        // ALU write
        drive_cycle(1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 3'd0, 5'd5, 5'd0);
        check("alu_reg5", bus.RD1, 32'h1234_5678);
        check("alu_count", bus.WriteCount, 32'd1);

        // Load extension table
        check_ext(3'd1, 2'd3, 32'hFFFF_FF80);
        check_ext(3'd2, 2'd3, 32'h0000_0080);
        check_ext(3'd3, 2'd2, 32'hFFFF_80FF);
        check_ext(3'd4, 2'd0, 32'h0000_7F01);
        check_ext(3'd6, 2'd1, 32'h80FF_7F01);
        check_ext(3'd3, 2'd1, 32'h0000_7F01);

        // $0 protection
        drive_cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd0, 3'd0, 5'd0, 5'd0);
        check("zero_rd", bus.RD1, 32'h0);
        check("zero_count", bus.WriteCount, 32'd1);

        // Same-cycle hazard on reg 7
        drive_cycle(1'b1, 1'b0, 32'h11, 32'h0, 5'd7, 3'd0, 5'd0, 5'd7);
        @(negedge Clk);
        bus.W_RegWrite  = 1'b1;
        bus.W_MemtoReg  = 1'b0;
        bus.W_ALUanswer = 32'h22;
        bus.W_WriteReg  = 5'd7;
        bus.RA2         = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_pre", bus.RD2, 32'h22);
`else
        check("hazard_pre", bus.RD2, 32'h11);
`endif
        @(posedge Clk);
        model_regs[7] = 32'h22;
        model_count   = model_count + 32'd1;
        #1;
        bus.W_RegWrite = 1'b0;
        #1;
        check("hazard_post", bus.RD2, 32'h22);
        check("hazard_count", bus.WriteCount, model_count);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            wr = 5'($urandom_range(0, 31));
            drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
                        $urandom, wr, 3'($urandom_range(0, 7)),
                        ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                        ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
        end

        // Async reset mid-cycle with a write pending
        drive_cycle(1'b1, 1'b0, 32'hA1, 32'h0, 5'd1, 3'd0, 5'd1, 5'd0);
        drive_cycle(1'b1, 1'b0, 32'hA2, 32'h0, 5'd2, 3'd0, 5'd2, 5'd0);
        drive_cycle(1'b1, 1'b0, 32'hA3, 32'h0, 5'd3, 3'd0, 5'd3, 5'd0);
        @(negedge Clk);
        bus.W_RegWrite  = 1'b1;
        bus.W_MemtoReg  = 1'b0;
        bus.W_ALUanswer = 32'h99;
        bus.W_WriteReg  = 5'd4;
        bus.RA1         = 5'd1;
        bus.RA2         = 5'd4;
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check("arst_rd1", bus.RD1, 32'h0);
        check("arst_rd2", bus.RD2, 32'h0);
        check("arst_count", bus.WriteCount, 32'h0);
        @(posedge Clk);
        #1;
        check("arst_blocked_rd2", bus.RD2, 32'h0);
        check("arst_blocked_count", bus.WriteCount, 32'h0);
        @(negedge Clk);
        bus.W_RegWrite = 1'b0;
        Reset = 1'b1;

        drive_cycle(1'b1, 1'b1, 32'h2, 32'h80FF_7F01, 5'd9, 3'd1, 5'd9, 5'd3);
        check("post_rst_count", bus.WriteCount, 32'd1);
        for (int n = 0; n < 20; n++) begin
            drive_cycle(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                        5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
